// File: rtl/relay_toggle_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : relay_sched_pkg
// Description : Shared types and defaults for the relay toggle scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package relay_sched_pkg;

    // Scheduler phases: grant, issue the start pulse, wait for completion, settle gap
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        SETTLE = 2'd3
    } relay_sched_state_t;

    localparam int c_CMD_CH_W = 2;

    // One relay command as seen by RelayController
    typedef struct packed {
        logic                  dir;
        logic [c_CMD_CH_W-1:0] channel;
    } relay_cmd_t;

    // 100 ms and 10 ms at 250 MHz
    localparam int c_TIMEOUT_CYCLES_DEFAULT = 25000000;
    localparam int c_SETTLE_CYCLES_DEFAULT  = 2500000;

    // Width of a saturating counter able to reach the larger of two limits
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage : relay_sched_pkg
`default_nettype wire

// File: rtl/relay_toggle_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_pick
// Description : Combinational round-robin picker. Returns the first set
//               request bit found searching upward (with wrap) from i_rr_ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_pick #(
    parameter int NUM_CH = 4,
    localparam int c_CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [c_CH_W-1:0] i_rr_ptr,
    output logic [c_CH_W-1:0] o_grant_idx,
    output logic              o_grant_valid
);

    localparam logic [c_CH_W:0] c_NUM_CH = (c_CH_W + 1)'(NUM_CH);

    logic [c_CH_W:0]   w_sum;
    logic [c_CH_W-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest hit is written last and wins
    always_comb begin
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        w_sum         = '0;
        w_idx         = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_sum = {1'b0, i_rr_ptr} + (c_CH_W + 1)'(i);
            if (w_sum >= c_NUM_CH) begin
                w_sum = w_sum - c_NUM_CH;
            end
            w_idx = w_sum[c_CH_W-1:0];
            if (i_req[w_idx]) begin
                o_grant_idx   = w_idx;
                o_grant_valid = 1'b1;
            end
        end
    end

endmodule : rr_priority_pick
`default_nettype wire

// File: rtl/relay_toggle_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : relay_toggle_scheduler
// Description : Queues one relay toggle per channel, grants channels round-
//               robin, issues each to RelayController, waits for done or
//               timeout, then enforces a settle gap before the next grant.
//               SETTLE_CYCLES and TIMEOUT_CYCLES must be at least 1.
// Revision    : 1.0 - initial release
// ============================================================================
module relay_toggle_scheduler
    import relay_sched_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES_DEFAULT,
    parameter int SETTLE_CYCLES  = c_SETTLE_CYCLES_DEFAULT,
    localparam int c_CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    input  logic [c_CH_W-1:0] i_req_channel,
    input  logic              i_req_dir,
    input  logic              i_err_clear,
    output logic              o_toggle_en,
    output logic              o_toggle_dir,
    output logic [c_CH_W-1:0] o_toggle_channel,
    input  logic              i_toggle_done,
    output logic              o_busy,
    output logic [NUM_CH-1:0] o_pending,
    output logic [NUM_CH-1:0] o_relay_state,
    output logic              o_done_valid,
    output logic              o_timeout_err,
    output logic [c_CH_W-1:0] o_err_channel
);

    localparam int               c_CNT_W        = cnt_width(TIMEOUT_CYCLES, SETTLE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST  = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX      = '1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);
    localparam logic [c_CH_W-1:0]  c_LAST_CH      = c_CH_W'(NUM_CH - 1);
    localparam logic [c_CH_W-1:0]  c_CH_ONE       = c_CH_W'(1);

    relay_sched_state_t  r_state;
    logic [NUM_CH-1:0]   r_pending;
    logic [NUM_CH-1:0]   r_pend_dir;
    logic [c_CH_W-1:0]   r_rr_ptr;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_toggle_en;
    logic                r_toggle_dir;
    logic [c_CH_W-1:0]   r_toggle_channel;
    logic                r_busy;
    logic [NUM_CH-1:0]   r_relay_state;
    logic                r_done_valid;
    logic                r_timeout_err;
    logic [c_CH_W-1:0]   r_err_channel;

    logic [c_CH_W-1:0]   w_grant_idx;
    logic                w_grant_valid;
    logic [c_CH_W-1:0]   w_next_ptr;

    rr_priority_pick #(
        .NUM_CH (NUM_CH)
    ) u_pick (
        .i_req         (r_pending),
        .i_rr_ptr      (r_rr_ptr),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    // Fairness: the channel just serviced drops to lowest priority
    always_comb begin
        w_next_ptr = (r_toggle_channel == c_LAST_CH) ? '0 : (r_toggle_channel + c_CH_ONE);
    end

    // Scheduler FSM together with the request queue and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_pending        <= '0;
            r_pend_dir       <= '0;
            r_rr_ptr         <= '0;
            r_cnt            <= '0;
            r_toggle_en      <= 1'b0;
            r_toggle_dir     <= 1'b0;
            r_toggle_channel <= '0;
            r_busy           <= 1'b0;
            r_relay_state    <= '0;
            r_done_valid     <= 1'b0;
            r_timeout_err    <= 1'b0;
            r_err_channel    <= '0;
        end else begin
            r_toggle_en  <= 1'b0;
            r_done_valid <= 1'b0;

            // A timeout later in this block overrides the clear
            if (i_err_clear) begin
                r_timeout_err <= 1'b0;
                r_err_channel <= '0;
            end

            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_toggle_channel        <= w_grant_idx;
                        r_toggle_dir            <= r_pend_dir[w_grant_idx];
                        r_pending[w_grant_idx]  <= 1'b0;
                        r_busy                  <= 1'b1;
                        r_state                 <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_toggle_en <= 1'b1;
                    r_cnt       <= '0;
                    r_state     <= WAIT;
                end
                WAIT: begin
                    if (i_toggle_done) begin
                        r_relay_state[r_toggle_channel] <= r_toggle_dir;
                        r_done_valid                    <= 1'b1;
                        r_cnt                           <= '0;
                        r_state                         <= SETTLE;
                    end else if (r_cnt >= c_TIMEOUT_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_err_channel <= r_toggle_channel;
                        r_cnt         <= '0;
                        r_state       <= SETTLE;
                    end else if (r_cnt != c_CNT_MAX) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                SETTLE: begin
                    if (r_cnt >= c_SETTLE_LAST) begin
                        r_rr_ptr <= w_next_ptr;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end else if (r_cnt != c_CNT_MAX) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // New request overrides a same-cycle grant clear (set wins, latest dir wins)
            if (i_req_valid) begin
                r_pending[i_req_channel]  <= 1'b1;
                r_pend_dir[i_req_channel] <= i_req_dir;
            end
        end
    end

    assign o_toggle_en      = r_toggle_en;
    assign o_toggle_dir     = r_toggle_dir;
    assign o_toggle_channel = r_toggle_channel;
    assign o_busy           = r_busy;
    assign o_pending        = r_pending;
    assign o_relay_state    = r_relay_state;
    assign o_done_valid     = r_done_valid;
    assign o_timeout_err    = r_timeout_err;
    assign o_err_channel    = r_err_channel;

endmodule : relay_toggle_scheduler
`default_nettype wire

// File: tb/tb_relay_toggle_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_relay_toggle_scheduler
// Description : Randomized bench for relay_toggle_scheduler with a timeline
//               reference model and an event scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_relay_toggle_scheduler;

    localparam int N   = 4;
    localparam int TMO = 100;
    localparam int STL = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_req_valid;
    logic [1:0] i_req_channel;
    logic       i_req_dir;
    logic       i_err_clear;
    logic       i_toggle_done;
    logic       o_toggle_en;
    logic       o_toggle_dir;
    logic [1:0] o_toggle_channel;
    logic       o_busy;
    logic [3:0] o_pending;
    logic [3:0] o_relay_state;
    logic       o_done_valid;
    logic       o_timeout_err;
    logic [1:0] o_err_channel;

    always #2 clk = ~clk;

    relay_toggle_scheduler #(
        .NUM_CH         (N),
        .TIMEOUT_CYCLES (TMO),
        .SETTLE_CYCLES  (STL)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_req_valid      (i_req_valid),
        .i_req_channel    (i_req_channel),
        .i_req_dir        (i_req_dir),
        .i_err_clear      (i_err_clear),
        .o_toggle_en      (o_toggle_en),
        .o_toggle_dir     (o_toggle_dir),
        .o_toggle_channel (o_toggle_channel),
        .i_toggle_done    (i_toggle_done),
        .o_busy           (o_busy),
        .o_pending        (o_pending),
        .o_relay_state    (o_relay_state),
        .o_done_valid     (o_done_valid),
        .o_timeout_err    (o_timeout_err),
        .o_err_channel    (o_err_channel)
    );

    typedef struct {int at; int ch; bit dir;} en_ev_t;
    typedef struct {int at; logic [3:0] rs;} done_ev_t;

    en_ev_t   q_en[$];
    done_ev_t q_done[$];

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Reference model: pending table plus a timeline of the operation in flight.
    // m_phase: 0 idle, 1 operation in flight (issue+wait), 2 settle gap.
    bit         m_pend[N];
    bit         m_pdir[N];
    int         m_rr;
    int         m_phase;
    int         m_end;
    bit         m_ok;
    int         m_settle_end;
    int         m_ch;
    bit         m_dir;
    logic [3:0] m_rs;
    bit         m_err;
    int         m_errch;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic logic [3:0] pend_vec();
        logic [3:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_pdir[i] = 1'b0;
        end
        m_rr = 0; m_phase = 0; m_end = 0; m_ok = 1'b0; m_settle_end = 0;
        m_ch = 0; m_dir = 1'b0; m_rs = '0; m_err = 1'b0; m_errch = 0;
        q_en.delete();
        q_done.delete();
    endfunction

    // Apply the effects of the clock edge numbered edge_n
    function automatic void model_step(input bit req, input int rch, input bit rdir, input bit clr);
        bit       was_idle;
        bit       to_now;
        int       k;
        int       r;
        int       c;
        bit       found;
        en_ev_t   ee;
        done_ev_t de;
        was_idle = (m_phase == 0);
        to_now   = 1'b0;
        if (m_phase == 1 && edge_n == m_end) begin
            if (m_ok) begin
                m_rs[m_ch] = m_dir;
                de.at = edge_n; de.rs = m_rs;
                q_done.push_back(de);
            end else begin
                m_err = 1'b1; m_errch = m_ch; to_now = 1'b1;
            end
            m_phase = 2;
            m_settle_end = edge_n + STL;
        end else if (m_phase == 2 && edge_n == m_settle_end) begin
            m_rr = (m_ch + 1) % N;
            m_phase = 0;
        end
        if (clr && !to_now) begin
            m_err = 1'b0; m_errch = 0;
        end
        if (was_idle) begin
            found = 1'b0;
            for (int i = 0; i < N; i++) begin
                c = (m_rr + i) % N;
                if (!found && m_pend[c]) begin
                    found = 1'b1;
                    m_ch = c;
                end
            end
            if (found) begin
                m_dir = m_pdir[m_ch];
                m_pend[m_ch] = 1'b0;
                ee.at = edge_n + 1; ee.ch = m_ch; ee.dir = m_dir;
                q_en.push_back(ee);
                m_phase = 1;
                r = $urandom_range(0, 7);
                if (r < 2) begin
                    m_ok = 1'b0;
                    m_end = edge_n + 1 + TMO;
                end else begin
                    m_ok = 1'b1;
                    if (r == 2)      k = TMO - 1;
                    else if (r == 3) k = TMO - 2;
                    else             k = $urandom_range(0, 60);
                    m_end = edge_n + 2 + k;
                end
            end
        end
        if (req) begin
            m_pend[rch] = 1'b1;
            m_pdir[rch] = rdir;
        end
    endfunction

    // One clock: drive inputs, take the edge, advance the model
    task automatic cycle(input bit req, input int rch, input bit rdir, input bit clr, input bit dn);
        i_req_valid   = req;
        i_req_channel = 2'(rch);
        i_req_dir     = rdir;
        i_err_clear   = clr;
        i_toggle_done = dn;
        @(posedge clk);
        edge_n++;
        if (rst_n) model_step(req, rch, rdir, clr);
        #1;
    endtask

    // Random traffic; toggle_done follows the model's plan, plus stray pulses outside WAIT
    task automatic rand_cycle(input bit allow_req);
        int nxt;
        bit dn;
        bit clr;
        bit req;
        nxt = edge_n + 1;
        if (m_phase == 1) dn = m_ok && (m_end == nxt);
        else              dn = ($urandom_range(0, 15) == 0);
        if (m_phase == 1 && !m_ok && m_end == nxt) clr = 1'($urandom_range(0, 1));
        else                                       clr = ($urandom_range(0, 31) == 0);
        req = allow_req && ($urandom_range(0, 5) == 0);
        cycle(req, $urandom_range(0, N - 1), 1'($urandom_range(0, 1)), clr, dn);
    endtask

    // Monitor: level checks every cycle, event checks against the scoreboard queues
    en_ev_t   mon_en;
    done_ev_t mon_done;
    always @(negedge clk) begin
        chk("busy",         32'(o_busy),           32'(m_phase != 0));
        chk("pending",      32'(o_pending),        32'(pend_vec()));
        chk("relay_state",  32'(o_relay_state),    32'(m_rs));
        chk("timeout_err",  32'(o_timeout_err),    32'(m_err));
        chk("err_channel",  32'(o_err_channel),    32'(m_errch));
        chk("toggle_chan",  32'(o_toggle_channel), 32'(m_ch));
        chk("toggle_dir",   32'(o_toggle_dir),     32'(m_dir));
        if (o_toggle_en) begin
            if (q_en.size() == 0) begin
                chk("toggle_en_unexpected", 32'(o_toggle_en), 32'd0);
            end else begin
                mon_en = q_en.pop_front();
                chk("toggle_en_edge", 32'(edge_n), 32'(mon_en.at));
                chk("toggle_en_chan", 32'(o_toggle_channel), 32'(mon_en.ch));
                chk("toggle_en_dir",  32'(o_toggle_dir), 32'(mon_en.dir));
            end
        end else if (q_en.size() != 0 && q_en[0].at <= edge_n) begin
            chk("toggle_en_missing", 32'(o_toggle_en), 32'd1);
            void'(q_en.pop_front());
        end
        if (o_done_valid) begin
            if (q_done.size() == 0) begin
                chk("done_valid_unexpected", 32'(o_done_valid), 32'd0);
            end else begin
                mon_done = q_done.pop_front();
                chk("done_edge",   32'(edge_n), 32'(mon_done.at));
                chk("done_rstate", 32'(o_relay_state), 32'(mon_done.rs));
            end
        end else if (q_done.size() != 0 && q_done[0].at <= edge_n) begin
            chk("done_valid_missing", 32'(o_done_valid), 32'd1);
            void'(q_done.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
        $fatal(1);
    end

    initial begin
        int guard;
        model_reset();
        rst_n = 1'b0;
        i_req_valid = 1'b0; i_req_channel = '0; i_req_dir = 1'b0;
        i_err_clear = 1'b0; i_toggle_done = 1'b0;
        repeat (3) cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Opening transaction: channel 2, direction 1
        cycle(1'b1, 2, 1'b1, 1'b0, 1'b0);
        repeat (4000) rand_cycle(1'b1);

        // Reset while an operation is waiting for done
        guard = 0;
        while (!(m_phase == 1 && m_end > edge_n + 5) && guard < 3000) begin
            rand_cycle(1'b1);
            guard++;
        end
        chk("reached_wait_before_reset", 32'(m_phase), 32'd1);
        rst_n = 1'b0;
        model_reset();
        repeat (2) cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        // Late done from the aborted operation must be ignored
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
        repeat (50) rand_cycle(1'b0);

        repeat (1500) rand_cycle(1'b1);

        // Drain everything still queued
        guard = 0;
        while (!(m_phase == 0 && pend_vec() == 4'b0) && guard < 3000) begin
            rand_cycle(1'b0);
            guard++;
        end
        repeat (3) rand_cycle(1'b0);
        chk("drain_idle",       32'(m_phase), 32'd0);
        chk("q_en_leftover",    32'(q_en.size()), 32'd0);
        chk("q_done_leftover",  32'(q_done.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_relay_toggle_scheduler
`default_nettype wire
